// File: rtl/wb_reg_seq_pkg.sv
// Shared definitions for the write-back sequencer: address selects, control bit
// positions and FSM state encoding.
package wb_pkg;

  localparam int unsigned CNT_WIDTH   = 5;
  localparam int unsigned CNT_W       = 0;
  localparam int unsigned CNT_DSEL    = 1;
  localparam int unsigned CNT_ASEL_LO = 2;
  localparam int unsigned CNT_ASEL_HI = 4;

  localparam logic [2:0] WA_RD    = 3'b000;
  localparam logic [2:0] WA_MULRD = 3'b001;
  localparam logic [2:0] WA_LIST  = 3'b010;
  localparam logic [2:0] WA_BASE  = 3'b011;
  localparam logic [2:0] WA_LR    = 3'b101;
  localparam logic [2:0] WA_LISTB = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LIST = 2'd1,
    BASE = 2'd2
  } wb_state_e;

  function automatic logic is_list_sel(input logic [2:0] asel);
    return (asel == WA_LIST) || (asel == WA_LISTB);
  endfunction

endpackage

// File: rtl/wb_reg_seq_if.sv
// Write-back control/data bundle between upstream pipeline and the sequencer.
interface wb_reg_seq_if #(
  parameter int unsigned DATA_W = 32
);
  logic              WB_VALID;
  logic [4:0]        WB_CNT;
  logic [31:0]       OPCODE;
  logic [DATA_W-1:0] ALU_RES;
  logic [DATA_W-1:0] MEM_DATA;
  logic              MEM_RDY;
  logic [DATA_W-1:0] PC_PLUS4;
  logic              REG_W;
  logic [3:0]        REG_WADD;
  logic [DATA_W-1:0] REG_WDAT;
  logic              BUSY;
  logic              DONE;
  logic              PC_FLUSH;

  modport master (
    output WB_VALID, WB_CNT, OPCODE, ALU_RES, MEM_DATA, MEM_RDY, PC_PLUS4,
    input  REG_W, REG_WADD, REG_WDAT, BUSY, DONE, PC_FLUSH
  );

  modport slave (
    input  WB_VALID, WB_CNT, OPCODE, ALU_RES, MEM_DATA, MEM_RDY, PC_PLUS4,
    output REG_W, REG_WADD, REG_WDAT, BUSY, DONE, PC_FLUSH
  );
endinterface

// File: rtl/wb_reg_seq_prio_enc16.sv
// Lowest-set-bit priority encoder for the load-multiple register mask.
module wb_prio_enc16 (
  input  logic [15:0] mask_i,
  output logic [3:0]  idx_o,
  output logic        any_o
);

  // Descending scan so the lowest set bit is the last assignment.
  always_comb begin
    idx_o = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (mask_i[i]) idx_o = 4'(i);
    end
  end

  assign any_o = |mask_i;

endmodule

// File: rtl/wb_reg_seq.sv
// Write-back sequencer: single register writes and LDM list walking.
// Optional macro WB_PC_FLUSH_EN enables PC_FLUSH on writes to r15.
module wb_reg_seq
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LR_IDX = 14
) (
  input  logic        CLK,
  input  logic        RST,
  wb_reg_seq_if.slave bus
);

  wb_state_e         state_q, state_d;
  logic [15:0]       mask_q, mask_d;
  logic [3:0]        rn_q, rn_d;
  logic              list_wb_q, list_wb_d;
  logic              reg_w_q, reg_w_d;
  logic [3:0]        reg_wadd_q, reg_wadd_d;
  logic [DATA_W-1:0] reg_wdat_q, reg_wdat_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [2:0]        asel;
  logic              wen, dsel, sel_list, sel_rsvd, need_mem, list_empty;
  logic [3:0]        single_wadd;
  logic [DATA_W-1:0] single_wdat;
  logic [3:0]        pe_idx;
  logic              pe_any, last_beat;
  logic [15:0]       mask_clr;
  logic              unused_opc;

  assign asel       = bus.WB_CNT[CNT_ASEL_HI:CNT_ASEL_LO];
  assign wen        = bus.WB_CNT[CNT_W];
  assign dsel       = bus.WB_CNT[CNT_DSEL];
  assign sel_list   = is_list_sel(asel);
  assign sel_rsvd   = !(sel_list || asel == WA_RD || asel == WA_MULRD ||
                        asel == WA_BASE || asel == WA_LR);
  assign need_mem   = dsel && (asel == WA_RD || asel == WA_MULRD);
  assign list_empty = (bus.OPCODE[15:0] == 16'd0);
  assign unused_opc = ^bus.OPCODE[31:20];

  wb_prio_enc16 u_prio (
    .mask_i (mask_q),
    .idx_o  (pe_idx),
    .any_o  (pe_any)
  );

  assign mask_clr  = mask_q & ~(16'd1 << pe_idx);
  assign last_beat = (mask_clr == 16'd0);

  // Index/data for non-list writes, including the forced-data selects.
  always_comb begin
    single_wadd = 4'd0;
    single_wdat = dsel ? bus.MEM_DATA : bus.ALU_RES;
    case (asel)
      WA_RD:    single_wadd = bus.OPCODE[15:12];
      WA_MULRD: single_wadd = bus.OPCODE[19:16];
      WA_BASE: begin
        single_wadd = bus.OPCODE[19:16];
        single_wdat = bus.ALU_RES;
      end
      WA_LR: begin
        single_wadd = 4'(LR_IDX);
        single_wdat = bus.PC_PLUS4;
      end
      default: single_wadd = 4'd0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.WB_VALID && sel_list && wen) begin
          if (!list_empty)            state_d = LIST;
          else if (asel == WA_LISTB)  state_d = BASE;
          else                        state_d = IDLE;
        end
      end
      LIST: begin
        if (!pe_any || (bus.MEM_RDY && last_beat)) begin
          state_d = list_wb_q ? BASE : IDLE;
        end
      end
      BASE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    reg_w_d    = 1'b0;
    reg_wadd_d = 4'd0;
    reg_wdat_d = '0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    mask_d     = mask_q;
    rn_d       = rn_q;
    list_wb_d  = list_wb_q;
    case (state_q)
      IDLE: begin
        if (bus.WB_VALID) begin
          if (sel_list && wen) begin
            mask_d    = bus.OPCODE[15:0];
            rn_d      = bus.OPCODE[19:16];
            list_wb_d = (asel == WA_LISTB);
            if (list_empty && asel == WA_LIST) done_d = 1'b1;
            else                               busy_d = 1'b1;
          end else if (!wen || sel_rsvd || sel_list) begin
            done_d = 1'b1;
          end else if (need_mem && !bus.MEM_RDY) begin
            busy_d = 1'b1;
          end else begin
            reg_w_d    = 1'b1;
            reg_wadd_d = single_wadd;
            reg_wdat_d = single_wdat;
            done_d     = 1'b1;
          end
        end
      end
      LIST: begin
        busy_d = 1'b1;
        if (bus.MEM_RDY && pe_any) begin
          reg_w_d    = 1'b1;
          reg_wadd_d = pe_idx;
          reg_wdat_d = bus.MEM_DATA;
          mask_d     = mask_clr;
          if (last_beat && !list_wb_q) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end
        end else if (!pe_any && !list_wb_q) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      BASE: begin
        reg_w_d    = 1'b1;
        reg_wadd_d = rn_q;
        reg_wdat_d = bus.ALU_RES;
        done_d     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mask_q     <= 16'd0;
      rn_q       <= 4'd0;
      list_wb_q  <= 1'b0;
      reg_w_q    <= 1'b0;
      reg_wadd_q <= 4'd0;
      reg_wdat_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      mask_q     <= mask_d;
      rn_q       <= rn_d;
      list_wb_q  <= list_wb_d;
      reg_w_q    <= reg_w_d;
      reg_wadd_q <= reg_wadd_d;
      reg_wdat_q <= reg_wdat_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

`ifdef WB_PC_FLUSH_EN
  logic pc_flush_q;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) pc_flush_q <= 1'b0;
    else     pc_flush_q <= reg_w_d && (reg_wadd_d == 4'd15);
  end
  assign bus.PC_FLUSH = pc_flush_q;
`else
  assign bus.PC_FLUSH = 1'b0;
`endif

  assign bus.REG_W    = reg_w_q;
  assign bus.REG_WADD = reg_wadd_q;
  assign bus.REG_WDAT = reg_wdat_q;
  assign bus.BUSY     = busy_q;
  assign bus.DONE     = done_q;

endmodule

// File: tb/tb_wb_reg_seq.sv
// Directed testbench for wb_reg_seq: single-write vector table plus LDM,
// reset-abort and busy-hold sequences.
module tb_wb_reg_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  wb_reg_seq_if #(.DATA_W(32)) bus ();

  wb_reg_seq #(.DATA_W(32), .LR_IDX(14)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  cnt;
    logic [31:0] opc;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] pc4;
    logic        rdy;
    logic        w;
    logic [3:0]  wadd;
    logic [31:0] wdat;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string tag, input string fld, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got 0x%0h want 0x%0h", tag, fld, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic w, input logic [3:0] a,
                            input logic [31:0] d, input logic dn, input logic bz);
    logic pf;
`ifdef WB_PC_FLUSH_EN
    pf = w && (a == 4'd15);
`else
    pf = 1'b0;
`endif
    chk(tag, "REG_W",    32'(bus.REG_W),    32'(w));
    chk(tag, "REG_WADD", 32'(bus.REG_WADD), 32'(a));
    chk(tag, "REG_WDAT", bus.REG_WDAT,      d);
    chk(tag, "DONE",     32'(bus.DONE),     32'(dn));
    chk(tag, "BUSY",     32'(bus.BUSY),     32'(bz));
    chk(tag, "PC_FLUSH", 32'(bus.PC_FLUSH), 32'(pf));
  endtask

  task automatic drive(input logic v, input logic [4:0] cnt, input logic [31:0] opc,
                       input logic [31:0] alu, input logic [31:0] mem,
                       input logic [31:0] pc4, input logic rdy);
    bus.WB_VALID = v;
    bus.WB_CNT   = cnt;
    bus.OPCODE   = opc;
    bus.ALU_RES  = alu;
    bus.MEM_DATA = mem;
    bus.PC_PLUS4 = pc4;
    bus.MEM_RDY  = rdy;
  endtask

  task automatic set_rdy(input logic rdy, input logic [31:0] mem);
    bus.MEM_RDY  = rdy;
    bus.MEM_DATA = mem;
  endtask

  initial begin
    vecs[0] = '{5'b00001, 32'h0000_3000, 32'h1234, 32'h0, 32'h0, 1'b0, 1'b1, 4'd3, 32'h1234};
    vecs[1] = '{5'b10101, 32'h0, 32'h0, 32'h0, 32'h108, 1'b0, 1'b1, 4'd14, 32'h108};
    vecs[2] = '{5'b10100, 32'h0, 32'h0, 32'h0, 32'h108, 1'b0, 1'b0, 4'd0, 32'h0};
    vecs[3] = '{5'b00011, 32'h0000_7000, 32'h11, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b1, 4'd7, 32'hDEAD_BEEF};
    vecs[4] = '{5'b00101, 32'h0009_2000, 32'hABCD, 32'h0, 32'h0, 1'b0, 1'b1, 4'd9, 32'hABCD};
    vecs[5] = '{5'b01111, 32'h0006_1000, 32'h44, 32'h55, 32'h0, 1'b0, 1'b1, 4'd6, 32'h44};
    vecs[6] = '{5'b10001, 32'h0000_2000, 32'h1, 32'h0, 32'h0, 1'b1, 1'b0, 4'd0, 32'h0};
    vecs[7] = '{5'b11101, 32'h0000_2000, 32'h1, 32'h0, 32'h0, 1'b1, 1'b0, 4'd0, 32'h0};
    vecs[8] = '{5'b00001, 32'h0000_F000, 32'h8000, 32'h0, 32'h0, 1'b0, 1'b1, 4'd15, 32'h8000};
    vecs[9] = '{5'b10111, 32'h0, 32'h9, 32'h77, 32'h200, 1'b0, 1'b1, 4'd14, 32'h200};

    drive(1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    #12;
    expect_out("reset", 1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Single-write table: accept one cycle, check result the next.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(1'b1, vecs[i].cnt, vecs[i].opc, vecs[i].alu, vecs[i].mem, vecs[i].pc4, vecs[i].rdy);
      @(negedge clk);
      expect_out($sformatf("vec%0d", i), vecs[i].w, vecs[i].wadd, vecs[i].wdat, 1'b1, 1'b0);
      drive(1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    end

    // Load single waiting on MEM_RDY.
    @(negedge clk);
    drive(1'b1, 5'b00011, 32'h0000_8000, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    expect_out("ldr_wait", 1'b0, 4'd0, 32'h0, 1'b0, 1'b1);
    set_rdy(1'b1, 32'hCAFE);
    @(negedge clk);
    expect_out("ldr_go", 1'b1, 4'd8, 32'hCAFE, 1'b1, 1'b0);
    drive(1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);

    // LDM {r1,r4,r15} with MEM_RDY 1,0,1,1.
    @(negedge clk);
    drive(1'b1, 5'b01011, 32'h0000_8012, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    expect_out("ldm_acc", 1'b0, 4'd0, 32'h0, 1'b0, 1'b1);
    set_rdy(1'b1, 32'hA);
    @(negedge clk);
    expect_out("ldm_r1", 1'b1, 4'd1, 32'hA, 1'b0, 1'b1);
    set_rdy(1'b0, 32'hF0);
    @(negedge clk);
    expect_out("ldm_hold", 1'b0, 4'd0, 32'h0, 1'b0, 1'b1);
    set_rdy(1'b1, 32'hB);
    @(negedge clk);
    expect_out("ldm_r4", 1'b1, 4'd4, 32'hB, 1'b0, 1'b1);
    set_rdy(1'b1, 32'hC);
    @(negedge clk);
    expect_out("ldm_r15", 1'b1, 4'd15, 32'hC, 1'b1, 1'b0);
    drive(1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);

    // LDM {r2} with base writeback to r5.
    @(negedge clk);
    drive(1'b1, 5'b11011, 32'h0005_0004, 32'h2004, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    expect_out("ldmb_acc", 1'b0, 4'd0, 32'h0, 1'b0, 1'b1);
    set_rdy(1'b1, 32'h77);
    @(negedge clk);
    expect_out("ldmb_r2", 1'b1, 4'd2, 32'h77, 1'b0, 1'b1);
    set_rdy(1'b0, 32'h0);
    @(negedge clk);
    expect_out("ldmb_r5", 1'b1, 4'd5, 32'h2004, 1'b1, 1'b0);
    drive(1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);

    // Empty list with writeback, then empty list without.
    @(negedge clk);
    drive(1'b1, 5'b11011, 32'h0005_0000, 32'h2004, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    expect_out("empty_b_acc", 1'b0, 4'd0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    expect_out("empty_b_r5", 1'b1, 4'd5, 32'h2004, 1'b1, 1'b0);
    drive(1'b1, 5'b01011, 32'h0005_0000, 32'h2004, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    expect_out("empty_done", 1'b0, 4'd0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);

    // Reset after first beat of a 4-register LDM.
    @(negedge clk);
    drive(1'b1, 5'b01011, 32'h0000_000F, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    set_rdy(1'b1, 32'h100);
    @(negedge clk);
    expect_out("rst_beat0", 1'b1, 4'd0, 32'h100, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    expect_out("rst_async", 1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 5'd0, 32'h0, 32'h0, 32'h101, 32'h0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    expect_out("rst_nowrite", 1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 5'b00001, 32'h0000_3000, 32'h5A5A, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    expect_out("rst_reaccept", 1'b1, 4'd3, 32'h5A5A, 1'b1, 1'b0);
    drive(1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);

    // WB_VALID held with a new instruction while BUSY is ignored.
    @(negedge clk);
    drive(1'b1, 5'b01011, 32'h0000_0040, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    drive(1'b1, 5'b00001, 32'h0000_9000, 32'h99, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    expect_out("hold_ign0", 1'b0, 4'd0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    expect_out("hold_ign1", 1'b0, 4'd0, 32'h0, 1'b0, 1'b1);
    set_rdy(1'b1, 32'h66);
    @(negedge clk);
    expect_out("hold_r6", 1'b1, 4'd6, 32'h66, 1'b1, 1'b0);
    @(negedge clk);
    expect_out("hold_r9", 1'b1, 4'd9, 32'h99, 1'b1, 1'b0);
    drive(1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    expect_out("idle_end", 1'b0, 4'd0, 32'h0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_reg_seq.md
Name: wb_reg_seq

Overview:
- Write-back sequencer downstream of the WB control ROM; consumes its 5-bit control word and drives the register-file write port.
- Single-write instructions (data processing, LDR, base writeback, branch-with-link): one registered write.
- LDM: walks the register list, one write per returned memory beat, optionally followed by a base writeback.
- Stalls upstream via BUSY while a list is in progress.

Parameters:
- DATA_W, 32, register/data width.
- LR_IDX, 14, register index written for link (branch-with-link).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- WB_VALID  in  1  instruction present at write-back this cycle.
- WB_CNT  in  5  control word: [4:2] address select, [1] data select (1=MEM_DATA), [0] write enable.
- OPCODE  in  32  instruction word.
- ALU_RES  in  DATA_W  ALU result / updated base address.
- MEM_DATA  in  DATA_W  load data beat.
- MEM_RDY  in  1  MEM_DATA valid this cycle.
- PC_PLUS4  in  DATA_W  return address for link.
- REG_W  out  1  register-file write strobe.
- REG_WADD  out  4  write register index.
- REG_WDAT  out  DATA_W  write data.
- BUSY  out  1  sequencer occupied; upstream holds the instruction and WB_VALID.
- DONE  out  1  one-cycle pulse when the instruction's last write issues.
- PC_FLUSH  out  1  see Optional Feature.

Behaviour:
- Reset (async, RST=1): state IDLE, pending mask 0. REG_W, REG_WADD, REG_WDAT, BUSY, DONE, PC_FLUSH all 0.
- All outputs are registered. Write latency is 1 cycle from acceptance or from a MEM_RDY beat.
- Address select decode:
  - 000: OPCODE[15:12] (Rd)
  - 001: OPCODE[19:16] (MUL Rd)
  - 011: OPCODE[19:16], data forced to ALU_RES (base writeback)
  - 101: LR_IDX, data forced to PC_PLUS4
  - 010: list
  - 110: list + base writeback
  - 100, 111: reserved, no write, DONE still pulses.
- Single write (IDLE, WB_VALID=1, select not list):
  - If WB_CNT[0]=1: next cycle REG_W=1 with the decoded index and data. Data is MEM_DATA if WB_CNT[1]=1, else ALU_RES, unless forced as above.
  - DONE=1 in the same cycle. BUSY stays 0.
  - If WB_CNT[0]=0: DONE pulses, REG_W=0.
  - Load single (data select 1) with MEM_RDY=0: acceptance waits in IDLE with BUSY=1 until MEM_RDY.
- List (IDLE, WB_VALID=1, WB_CNT[0]=1, select 010/110):
  - Load pending mask with OPCODE[15:0], latch Rn=OPCODE[19:16], go to LIST, BUSY=1 next cycle.
  - LIST: on each MEM_RDY=1, write MEM_DATA to the lowest set bit of the mask and clear that bit. MEM_RDY=0 means no write and hold.
  - When the final bit clears: select 010 → DONE with that write, then IDLE; select 110 → go to BASE.
  - BASE: write ALU_RES to latched Rn (no MEM_RDY needed), DONE, then IDLE.
  - BUSY deasserts in the cycle DONE is asserted.
  - Empty list (OPCODE[15:0]=0): no data writes; 010 → DONE next cycle; 110 → BASE.
  - Rn in the list with 110: base write comes last and wins.
- WB_VALID while BUSY=1 is ignored (no re-acceptance).
- RST asserted mid-list: immediate abort, mask cleared, no further writes.
- Pending mask never wraps. Writes are strictly ascending index, at most 16 data writes plus 1 base write.

Optional Feature:
- Macro WB_PC_FLUSH_EN.
- Defined: PC_FLUSH=1 in exactly the cycles where REG_W=1 and REG_WADD=4'd15 (single or list beat), registered with REG_W.
- Undefined: PC_FLUSH tied 0, no comparator logic.

Decomposition:
- Shared package wb_pkg:
  - address-select localparams (WA_RD=3'b000, WA_MULRD=3'b001, WA_LIST=3'b010, WA_BASE=3'b011, WA_LR=3'b101, WA_LISTB=3'b110)
  - control bit positions (CNT_W=0, CNT_DSEL=1, CNT_ASEL=4:2)
  - FSM state encoding IDLE/LIST/BASE.
- One sub-module, wb_prio_enc16: 16-bit mask in → 4-bit lowest-set index plus any-set flag, combinational.

Test Plan:
- Data processing: WB_CNT=5'b00001, OPCODE[15:12]=3, ALU_RES=0x1234 → next cycle REG_W=1, REG_WADD=3, REG_WDAT=0x1234, DONE=1, BUSY=0.
- Branch-with-link: WB_CNT=5'b10101, PC_PLUS4=0x0000_0108 → REG_WADD=14, REG_WDAT=0x108. With WB_CNT=5'b10100 → DONE only, REG_W=0.
- LDM {r1,r4,r15}, WB_CNT=5'b01011, MEM_RDY pattern 1,0,1,1 with data A,B,C → writes r1=A, r4=B, r15=C on consecutive MEM_RDY beats. BUSY=1 throughout, DONE with the r15 write. PC_FLUSH=1 on the r15 write when WB_PC_FLUSH_EN is defined.
- LDM with writeback, list {r2}, Rn=5, ALU_RES=0x2004, WB_CNT=5'b11011 → r2=MEM_DATA, then r5=0x2004 next cycle with DONE. Empty list with 110 → only the r5 write.
- RST pulsed after first beat of a 4-register LDM → all outputs 0 immediately, no further REG_W, BUSY=0. New WB_VALID after RST release is accepted normally.
- WB_VALID held with a different opcode while BUSY=1 → ignored. Accepted only on the cycle after DONE.
